iter_shifter: RTL and testbench
===============================

ITER_SHIFTER -- requirements
Module: iter_shifter

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; SHALL be a power of 2, 8..64.
REQ-002 Parameter STEP, default 4, maximum shift distance applied per cycle; SHALL be a power of 2, 1..WIDTH.
REQ-003 Derived SHAMT_W = log2(WIDTH), shift-amount width (5 at WIDTH=32).
REQ-004 Port clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port rst  input  1  synchronous, active-high reset.
REQ-006 Port in_valid  input  1  operand, shamt and alu valid.
REQ-007 Port in_ready  output  1  block can accept a new operation.
REQ-008 Port in  input  WIDTH  operand.
REQ-009 Port shamt  input  SHAMT_W  shift amount.
REQ-010 Port alu  input  2  mode: 00 SLL, 01 SRA, 10 SRL, 11 ROR (rotate right).
REQ-011 Port out_valid  output  1  result valid.
REQ-012 Port out_ready  input  1  consumer accepts result.
REQ-013 Port out  output  WIDTH  result, registered.
REQ-014 Port busy  output  1  high whenever state is not IDLE.

Function
REQ-015 FSM states SHALL be IDLE, SHIFT, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-016 Accept SHALL occur on a rising edge with in_valid && in_ready; in, shamt, alu captured into internal registers; remaining-count register loaded with shamt.
REQ-017 On accept: shamt==0 -> DONE with out = in; shamt!=0 -> SHIFT.
REQ-018 Each SHIFT cycle SHALL shift the working value by d = min(STEP, remaining) in the captured mode and decrement remaining by d; when remaining becomes 0 the FSM SHALL enter DONE on the same edge.
REQ-019 Latency from accept edge to first cycle with out_valid high SHALL be 1 + ceil(shamt/STEP) cycles (1 when shamt==0).
REQ-020 SLL and SRL SHALL fill vacated bits with 0; SRA SHALL fill with bit WIDTH-1 of the captured operand; ROR SHALL wrap bits shifted out of bit 0 into bit WIDTH-1.
REQ-021 Result SHALL equal the single-cycle result for every shamt in 0..WIDTH-1 (no wrap of shamt, no overshift).
REQ-022 Input ports SHALL be ignored outside the accept edge; changes during SHIFT/DONE SHALL NOT affect the result.
REQ-023 In DONE, out and out_valid SHALL hold stable until out_ready is high; on out_valid && out_ready the FSM SHALL return to IDLE on that edge.
REQ-024 No accept SHALL occur in the DONE->IDLE handoff cycle (in_ready low in DONE); minimum issue interval is 2 + ceil(shamt/STEP) cycles.
REQ-025 out SHALL retain the last result while in IDLE until the next DONE update.
REQ-026 out_ready while not in DONE SHALL have no effect.

Reset
REQ-027 With rst high at a rising edge: state=IDLE, out=0, out_valid=0, busy=0, remaining=0, in_ready=1 in the following cycle.
REQ-028 rst SHALL take priority over accept, shifting and result handshake; an operation in flight SHALL be discarded with no out_valid pulse.

Verification (WIDTH=32, STEP=4)
REQ-029 SLL in=0x0000_0001 shamt=31 -> out=0x8000_0000, out_valid first high 9 cycles after accept.
REQ-030 SRA in=0x8000_0000 shamt=4 -> out=0xF800_0000, latency 2; SRL same operands -> 0x0800_0000.
REQ-031 ROR in=0x0000_0001 shamt=1 -> out=0x8000_0000, latency 2; ROR in=0x1234_5678 shamt=8 -> 0x7812_3456, latency 3.
REQ-032 shamt=0, in=0xDEAD_BEEF, out_ready held low 3 cycles -> out=0xDEAD_BEEF stable, out_valid high, in_ready low, busy high throughout; IDLE one cycle after out_ready rises.
REQ-033 Operation SRL shamt=20 accepted, in toggled during SHIFT, rst asserted on 3rd SHIFT cycle -> next cycle in_ready=1, out_valid=0, out=0, no result ever presented.
REQ-034 Randomised sweep of all alu modes and shamt 0..31 against a single-cycle model, with random out_ready back-pressure -> every result matches, latency per REQ-019.

Source files
------------

// File: rtl/iter_shifter.sv
// Multi-cycle shifter: SLL/SRA/SRL/ROR applied STEP bits per cycle.
// Valid/ready on both sides; result register holds until consumed.
module iter_shifter #(
   parameter  int WIDTH   = 32,
   parameter  int STEP    = 4,
   localparam int SHAMT_W = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in,
   input  logic [SHAMT_W-1:0] shamt,
   input  logic [1:0]         alu,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out,
   output logic               busy
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_t;

   typedef enum logic [1:0] {
      M_SLL = 2'b00,
      M_SRA = 2'b01,
      M_SRL = 2'b10,
      M_ROR = 2'b11
   } mode_t;

   // STEP may equal WIDTH; the remaining count never exceeds WIDTH-1,
   // so the truncated STEP_LO is only selected when STEP < WIDTH.
   localparam logic [SHAMT_W:0]   STEP_M1 = (SHAMT_W+1)'(STEP - 1);
   localparam logic [SHAMT_W-1:0] STEP_LO = SHAMT_W'(STEP);

   state_t             state_q, state_d;
   mode_t              mode_q, mode_d;
   logic [WIDTH-1:0]   val_q, val_d;
   logic [WIDTH-1:0]   out_q, out_d;
   logic [SHAMT_W-1:0] rem_q, rem_d;
   logic [SHAMT_W-1:0] dist_c;
   logic [WIDTH-1:0]   shf_c;

   always_comb begin
      dist_c = rem_q;
      if ({1'b0, rem_q} > STEP_M1) begin
         dist_c = STEP_LO;
      end
   end

   // One constant-distance shifter per legal step, muxed by dist_c.
   always_comb begin
      shf_c = val_q;
      for (int k = 1; k <= STEP; k++) begin
         if (int'(dist_c) == k) begin
            unique case (mode_q)
               M_SLL: shf_c = val_q << k;
               M_SRA: shf_c = $signed(val_q) >>> k;
               M_SRL: shf_c = val_q >> k;
               M_ROR: shf_c = (val_q >> k) | (val_q << (WIDTH - k));
            endcase
         end
      end
   end

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      val_d   = val_q;
      out_d   = out_q;
      rem_d   = rem_q;
      unique case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               val_d  = in;
               mode_d = mode_t'(alu);
               rem_d  = shamt;
               if (shamt == '0) begin
                  out_d   = in;
                  state_d = S_DONE;
               end else begin
                  state_d = S_SHIFT;
               end
            end
         end
         S_SHIFT: begin
            val_d = shf_c;
            rem_d = rem_q - dist_c;
            if (rem_q == dist_c) begin
               out_d   = shf_c;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         mode_q  <= M_SLL;
         val_q   <= '0;
         out_q   <= '0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         val_q   <= val_d;
         out_q   <= out_d;
         rem_q   <= rem_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q != S_IDLE);
   assign out       = out_q;

endmodule

// File: tb/tb_iter_shifter.sv
// Bench for iter_shifter: directed cases, reset abort, random sweep
// against a single-cycle shift model with random back-pressure.
module tb_iter_shifter;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] din;
   logic [4:0]  shamt;
   logic [1:0]  alu;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] dout;
   logic        busy;

   int vectors;
   int errors;

   iter_shifter #(.WIDTH(32), .STEP(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in        (din),
      .shamt     (shamt),
      .alu       (alu),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (dout),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] ref_shift(input logic [1:0] m,
                                             input int s,
                                             input logic [31:0] x);
      logic [63:0] dbl;
      logic [31:0] r;
      dbl = {x, x};
      case (m)
         2'b00: r = x << s;
         2'b01: r = 32'($signed(x) >>> s);
         2'b10: r = x >> s;
         default: r = 32'(dbl >> s);
      endcase
      return r;
   endfunction

   function automatic int ref_lat(input int s);
      return 1 + (s + 3) / 4;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_op(input logic [1:0] m, input logic [4:0] s,
                        input logic [31:0] x, input int hold,
                        output logic [31:0] res, output int lat,
                        output bit stable);
      int guard;
      guard = 0;
      while (!in_ready && guard < 50) begin
         tick();
         guard++;
      end
      in_valid = 1'b1;
      alu      = m;
      shamt    = s;
      din      = x;
      tick();
      in_valid = 1'b0;
      lat      = 1;
      while (!out_valid && lat < 64) begin
         din       = $urandom;
         shamt     = 5'($urandom);
         alu       = 2'($urandom);
         out_ready = 1'($urandom);
         tick();
         lat++;
      end
      out_ready = 1'b0;
      res       = dout;
      stable    = 1'b1;
      for (int i = 0; i < hold; i++) begin
         din = $urandom;
         tick();
         if (dout !== res || out_valid !== 1'b1 ||
             in_ready !== 1'b0 || busy !== 1'b1) stable = 1'b0;
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      vectors += 4;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready got %b want 1", in_ready);
      end
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_out_valid got %b want 0", out_valid);
      end
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_busy got %b want 0", busy);
      end
      if (dout !== 32'h0) begin
         errors++;
         $display("FAIL reset_out got %h want 0", dout);
      end
   endtask

   task automatic test_directed();
      logic [1:0]  m [5]  = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11};
      logic [4:0]  s [5]  = '{5'd31, 5'd4, 5'd4, 5'd1, 5'd8};
      logic [31:0] x [5]  = '{32'h1, 32'h8000_0000, 32'h8000_0000,
                              32'h1, 32'h1234_5678};
      logic [31:0] e [5]  = '{32'h8000_0000, 32'hF800_0000,
                              32'h0800_0000, 32'h8000_0000,
                              32'h7812_3456};
      int          el [5] = '{9, 2, 2, 2, 3};
      logic [31:0] res;
      int          lat;
      bit          st;
      for (int i = 0; i < 5; i++) begin
         do_op(m[i], s[i], x[i], 1, res, lat, st);
         vectors += 2;
         if (res !== e[i]) begin
            errors++;
            $display("FAIL directed%0d_result got %h want %h", i, res, e[i]);
         end
         if (lat != el[i]) begin
            errors++;
            $display("FAIL directed%0d_latency got %0d want %0d",
                     i, lat, el[i]);
         end
      end
   endtask

   task automatic test_zero_hold();
      logic [31:0] res;
      int          lat;
      bit          st;
      do_op(2'b10, 5'd0, 32'hDEAD_BEEF, 3, res, lat, st);
      vectors += 5;
      if (res !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL zero_result got %h want deadbeef", res);
      end
      if (lat != 1) begin
         errors++;
         $display("FAIL zero_latency got %0d want 1", lat);
      end
      if (st !== 1'b1) begin
         errors++;
         $display("FAIL zero_hold_stable got %b want 1", st);
      end
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL zero_release got ready=%b busy=%b want 1 0",
                  in_ready, busy);
      end
      for (int i = 0; i < 3; i++) tick();
      if (dout !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL idle_retain got %h want deadbeef", dout);
      end
   endtask

   task automatic test_reset_midflight();
      int seen;
      in_valid = 1'b1;
      alu      = 2'b10;
      shamt    = 5'd20;
      din      = 32'hFFFF_0000;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         din = ~din;
         tick();
      end
      rst = 1'b1;
      din = ~din;
      tick();
      rst = 1'b0;
      vectors += 4;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL abort_in_ready got %b want 1", in_ready);
      end
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL abort_out_valid got %b want 0", out_valid);
      end
      if (dout !== 32'h0) begin
         errors++;
         $display("FAIL abort_out got %h want 0", dout);
      end
      seen = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (out_valid) seen++;
      end
      out_ready = 1'b0;
      if (seen != 0) begin
         errors++;
         $display("FAIL abort_no_result got %0d pulses want 0", seen);
      end
   endtask

   task automatic test_random();
      logic [1:0]  m;
      logic [4:0]  s;
      logic [31:0] x;
      logic [31:0] res;
      int          lat;
      bit          st;
      for (int i = 0; i < 200; i++) begin
         m = 2'($urandom);
         s = (i < 128) ? 5'(i % 32) : 5'($urandom_range(0, 31));
         x = $urandom;
         do_op(m, s, x, $urandom_range(0, 3), res, lat, st);
         vectors += 3;
         if (res !== ref_shift(m, int'(s), x)) begin
            errors++;
            $display("FAIL rand_result m=%0d s=%0d x=%h got %h want %h",
                     m, s, x, res, ref_shift(m, int'(s), x));
         end
         if (lat != ref_lat(int'(s))) begin
            errors++;
            $display("FAIL rand_latency s=%0d got %0d want %0d",
                     s, lat, ref_lat(int'(s)));
         end
         if (st !== 1'b1) begin
            errors++;
            $display("FAIL rand_hold_stable got %b want 1", st);
         end
      end
   endtask

   initial begin
      vectors   = 0;
      errors    = 0;
      rst       = 1'b0;
      in_valid  = 1'b0;
      din       = '0;
      shamt     = '0;
      alu       = '0;
      out_ready = 1'b0;
      #1;
      test_reset();
      test_directed();
      test_zero_hold();
      test_reset_midflight();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
